// File: rtl/uart_alu_interface_pkg.sv
// Shared constants for the UART-ALU command path: opcode values,
// one-hot FSM encodings and the default opcode width.
package uart_alu_pkg;

    localparam int NB_OP_DEFAULT = 6;

    localparam logic [NB_OP_DEFAULT-1:0] OP_ADD = 6'h20;
    localparam logic [NB_OP_DEFAULT-1:0] OP_SUB = 6'h22;
    localparam logic [NB_OP_DEFAULT-1:0] OP_AND = 6'h24;
    localparam logic [NB_OP_DEFAULT-1:0] OP_OR  = 6'h25;
    localparam logic [NB_OP_DEFAULT-1:0] OP_XOR = 6'h26;
    localparam logic [NB_OP_DEFAULT-1:0] OP_NOR = 6'h27;
    localparam logic [NB_OP_DEFAULT-1:0] OP_SRA = 6'h03;
    localparam logic [NB_OP_DEFAULT-1:0] OP_SRL = 6'h02;

    typedef enum logic [4:0] {
        ST_WAIT_A  = 5'b00001,
        ST_WAIT_B  = 5'b00010,
        ST_WAIT_OP = 5'b00100,
        ST_SEND    = 5'b01000,
        ST_WAIT_TX = 5'b10000
    } state_t;

endpackage

// File: rtl/uart_alu_interface_if.sv
// RX/TX handshake bundle between the UART stages and the command FSM.
// master = UART side, slave = uart_alu_interface.
interface uart_alu_interface_if #(
    parameter int NB_DATA = 8
) ();
    logic               i_rx_done;
    logic [NB_DATA-1:0] i_rx_data;
    logic               i_tick;
    logic               i_tx_done;
    logic               o_tx_start;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_busy;
    logic               o_drop;
    logic               o_timeout;

    modport master (
        output i_rx_done, i_rx_data, i_tick, i_tx_done,
        input  o_tx_start, o_tx_data, o_busy, o_drop, o_timeout
    );

    modport slave (
        input  i_rx_done, i_rx_data, i_tick, i_tx_done,
        output o_tx_start, o_tx_data, o_busy, o_drop, o_timeout
    );
endinterface

// File: rtl/uart_alu_interface_alu.sv
// Combinational ALU: NB_DATA-wide wrap-around result, unknown opcodes give 0.
module alu
    import uart_alu_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = NB_OP_DEFAULT
) (
    input  logic [NB_DATA-1:0] i_a,
    input  logic [NB_DATA-1:0] i_b,
    input  logic [NB_OP-1:0]   i_op,
    output logic [NB_DATA-1:0] o_result
);

    always_comb begin
        o_result = '0;
        case (i_op)
            OP_ADD: o_result = i_a + i_b;
            OP_SUB: o_result = i_a - i_b;
            OP_AND: o_result = i_a & i_b;
            OP_OR:  o_result = i_a | i_b;
            OP_XOR: o_result = i_a ^ i_b;
            OP_NOR: o_result = ~(i_a | i_b);
            // Shifts by >= NB_DATA already saturate to sign fill / zero.
            OP_SRA: o_result = $signed(i_a) >>> i_b;
            OP_SRL: o_result = i_a >> i_b;
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/uart_alu_interface.sv
// Assembles A, B, opcode from the UART RX byte stream and sends the ALU result to TX.
// Optional inter-byte timeout: define UART_ALU_INTERFACE_TIMEOUT_EN.
module uart_alu_interface
    import uart_alu_pkg::*;
#(
    parameter int          NB_DATA       = 8,
    parameter int          NB_OP         = NB_OP_DEFAULT,
    parameter logic [15:0] TIMEOUT_TICKS = 16'd4096
) (
    input logic                 i_clk,
    input logic                 i_reset,
    uart_alu_interface_if.slave bus
);

    state_t             state_q, state_d;
    logic [NB_DATA-1:0] a_q, b_q, result_q;
    logic [NB_OP-1:0]   op_q, alu_op;
    logic [NB_DATA-1:0] alu_result;
    logic               latch_a, latch_b, latch_op, clear_regs;
    logic               drop_d, drop_q;
    logic               timeout_d, timeout_q;
    logic               tmo_hit;

`ifdef UART_ALU_INTERFACE_TIMEOUT_EN
    logic [15:0] tick_cnt_q;
    logic        in_gap;

    assign in_gap  = (state_q == ST_WAIT_B) || (state_q == ST_WAIT_OP);
    assign tmo_hit = in_gap && bus.i_tick && (tick_cnt_q == TIMEOUT_TICKS - 16'd1);

    // Held at zero outside the gap states, so entering WAIT_B always starts from 0.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            tick_cnt_q <= '0;
        end else if (!in_gap || bus.i_rx_done || tmo_hit) begin
            tick_cnt_q <= '0;
        end else if (bus.i_tick) begin
            tick_cnt_q <= tick_cnt_q + 16'd1;
        end
    end
`else
    logic unused_tick;
    assign unused_tick = ^{bus.i_tick, TIMEOUT_TICKS};
    assign tmo_hit     = 1'b0;
`endif

    // The result is registered on the same edge the opcode arrives, so the ALU sees the live byte then.
    assign alu_op = latch_op ? bus.i_rx_data[NB_OP-1:0] : op_q;

    alu #(
        .NB_DATA (NB_DATA),
        .NB_OP   (NB_OP)
    ) u_alu (
        .i_a      (a_q),
        .i_b      (b_q),
        .i_op     (alu_op),
        .o_result (alu_result)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_WAIT_A;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        latch_a    = 1'b0;
        latch_b    = 1'b0;
        latch_op   = 1'b0;
        clear_regs = 1'b0;
        drop_d     = 1'b0;
        timeout_d  = 1'b0;
        case (state_q)
            ST_WAIT_A: begin
                if (bus.i_rx_done) begin
                    latch_a = 1'b1;
                    state_d = ST_WAIT_B;
                end
            end
            ST_WAIT_B: begin
                if (bus.i_rx_done) begin
                    latch_b = 1'b1;
                    state_d = ST_WAIT_OP;
                end else if (tmo_hit) begin
                    timeout_d = 1'b1;
                    state_d   = ST_WAIT_A;
                end
            end
            ST_WAIT_OP: begin
                if (bus.i_rx_done) begin
                    latch_op = 1'b1;
                    state_d  = ST_SEND;
                end else if (tmo_hit) begin
                    timeout_d = 1'b1;
                    state_d   = ST_WAIT_A;
                end
            end
            ST_SEND: begin
                drop_d  = bus.i_rx_done;
                state_d = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                drop_d = bus.i_rx_done;
                if (bus.i_tx_done) begin
                    state_d = ST_WAIT_A;
                end
            end
            default: begin
                clear_regs = 1'b1;
                state_d    = ST_WAIT_A;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            result_q  <= '0;
            drop_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            drop_q    <= drop_d;
            timeout_q <= timeout_d;
            if (clear_regs) begin
                a_q      <= '0;
                b_q      <= '0;
                op_q     <= '0;
                result_q <= '0;
            end else begin
                if (latch_a) begin
                    a_q <= bus.i_rx_data;
                end
                if (latch_b) begin
                    b_q <= bus.i_rx_data;
                end
                if (latch_op) begin
                    op_q     <= bus.i_rx_data[NB_OP-1:0];
                    result_q <= alu_result;
                end
            end
        end
    end

    assign bus.o_tx_start = (state_q == ST_SEND);
    assign bus.o_tx_data  = result_q;
    assign bus.o_busy     = (state_q == ST_SEND) || (state_q == ST_WAIT_TX);
    assign bus.o_drop     = drop_q;
    assign bus.o_timeout  = timeout_q;

endmodule

// File: doc/uart_alu_interface.md
Name: uart_alu_interface

Overview:
- Consumes the byte stream from the UART receiver (rx done pulse + data byte) and assembles a 3-byte command: operand A, operand B, opcode.
- Evaluates the opcode in an internal ALU, then drives the UART transmitter with the result byte.
- Performs a start/done handshake with the transmitter.
- Sits between the UART RX and TX stages in the UART-ALU top level.

Parameters:
- NB_DATA, 8, width of data bytes, operands and result.
- NB_OP, 6, opcode width; the low NB_OP bits of the opcode byte are used.
- TIMEOUT_TICKS, 16'd4096, number of baud ticks allowed between command bytes. Used only with the optional feature.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  asynchronous reset, active high.
- i_rx_done  in  1  one-cycle pulse: byte available from RX.
- i_rx_data  in  NB_DATA  received byte, valid while i_rx_done is high.
- i_tick  in  1  baud-rate generator tick. Used only by the timeout feature.
- i_tx_done  in  1  one-cycle pulse: TX finished its frame.
- o_tx_start  out  1  one-cycle pulse: begin transmitting o_tx_data.
- o_tx_data  out  NB_DATA  result byte; held stable from the start pulse until i_tx_done.
- o_busy  out  1  high in SEND and WAIT_TX.
- o_drop  out  1  one-cycle pulse: a byte arrived while busy and was discarded.
- o_timeout  out  1  one-cycle pulse: partial command aborted.

Behaviour:
- Clock and reset: single clock i_clk. i_reset is asynchronous, active high.
- Reset values: state=WAIT_A; A, B, OP and result registers = 0; tick counter = 0; o_tx_start=0, o_tx_data=0, o_busy=0, o_drop=0, o_timeout=0.
- The FSM is one-hot, 5 states:
  - WAIT_A: on i_rx_done, latch A and go to WAIT_B.
  - WAIT_B: on i_rx_done, latch B and go to WAIT_OP.
  - WAIT_OP: on i_rx_done, latch OP and go to SEND.
  - SEND: assert o_tx_start for exactly this one cycle, with o_tx_data = ALU(A,B,OP). Go to WAIT_TX.
  - WAIT_TX: on i_tx_done, go to WAIT_A. Otherwise hold.
  - Illegal/non-one-hot state: go to WAIT_A and clear all registers.
- Latency: the OP byte's i_rx_done in cycle N gives o_tx_start in cycle N+1.
- o_tx_data is registered when leaving WAIT_OP and holds until the next result.
- An i_rx_done in SEND or WAIT_TX discards the byte and pulses o_drop in the next cycle. The state is unchanged.
- i_tx_done seen outside WAIT_TX is ignored.
- If i_tx_done and i_rx_done coincide in WAIT_TX: go to WAIT_A, the byte is dropped (o_drop pulses), and it is NOT latched as A.
- ALU (combinational, NB_DATA wide, wrap-around, no carry out):
  - ADD 6'h20: A+B.
  - SUB 6'h22: A-B, modulo 2^NB_DATA.
  - AND 6'h24, OR 6'h25, XOR 6'h26, NOR 6'h27: bitwise.
  - SRA 6'h03: A arithmetic right shift by B.
  - SRL 6'h02: A logical right shift by B.
  - Shift amounts ≥ NB_DATA: SRA gives all sign bits, SRL gives 0.
  - Unknown opcode: result 0, still transmitted.
- Reset mid-command or mid-transmit: return immediately to WAIT_A, and any partial bytes are lost.

Optional Feature:
- Macro: UART_ALU_INTERFACE_TIMEOUT_EN.
- Defined: in WAIT_B and WAIT_OP, a 16-bit counter increments on each i_tick and clears on i_rx_done and on entry to WAIT_B.
  - When the count reaches TIMEOUT_TICKS-1 and i_tick is high: go to WAIT_A, clear the counter, pulse o_timeout for one cycle.
  - If i_rx_done coincides with the timeout: the byte wins, it is latched, and no timeout occurs.
- Undefined: no counter is built, o_timeout is tied to 0, and the FSM waits indefinitely between bytes.

Decomposition:
- Package uart_alu_pkg contains:
  - opcode constants (OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL);
  - one-hot state encodings (ST_WAIT_A, ST_WAIT_B, ST_WAIT_OP, ST_SEND, ST_WAIT_TX);
  - the NB_OP default.
- One sub-module: alu, a purely combinational block parameterised by NB_DATA and NB_OP, instantiated once.
- The FSM and registers stay in uart_alu_interface.

Test Plan:
1. Bytes 0x05, 0x03, 0x20 -> exactly one o_tx_start pulse one cycle after the third i_rx_done, o_tx_data=0x08; o_busy high until i_tx_done, then state=WAIT_A.
2. Wrap and shifts:
   - 0x03, 0x05, 0x22 -> 0xFE.
   - 0xFF, 0x01, 0x20 -> 0x00.
   - 0x80, 0x02, 0x03 -> 0xE0.
   - 0x80, 0x09, 0x02 -> 0x00.
3. Unknown opcode: 0x12, 0x34, 0x3F -> o_tx_data=0x00, with one o_tx_start pulse.
4. Two i_rx_done pulses during WAIT_TX, then i_tx_done -> two o_drop pulses and no state change. The next 3 bytes 0x0F, 0xF0, 0x25 give 0xFF.
5. Assert i_reset after the A and B bytes -> all outputs 0. After release, bytes 0x01, 0x01, 0x24 give 0x01.
6. With UART_ALU_INTERFACE_TIMEOUT_EN and TIMEOUT_TICKS=8: send byte 0x11, then 8 i_tick pulses with no byte -> one o_timeout pulse. The next three bytes 0x02, 0x02, 0x20 give 0x04.
